// File: rtl/depacketizer_pkg.sv
// ---------------------------------------------------------------------------
// depacketizer_pkg
// Shared definitions for the NoC depacketizer with per-VC buffering.
//   - Flit field positions for the default layout
//     {valid, head, tail, vc[0], dest[3:0], payload[27:0]} on a 36-bit flit.
//     Positions are the LSB of each field. DATA_POS is the LSB of the
//     WIDTH_DATA bits taken from the top of the payload.
//   - arb_state_t: packet-lock arbiter states.
//   - rr_next_grant(): round-robin pick among requesting VCs.
// ---------------------------------------------------------------------------
package depacketizer_pkg;

    // Default geometry that the field positions below describe.
    localparam int DEF_WIDTH_PKT        = 36;
    localparam int DEF_WIDTH_DATA       = 12;
    localparam int DEF_VC_ADDRESS_WIDTH = 1;
    localparam int DEF_ADDRESS_WIDTH    = 4;

    localparam int VALID_POS = DEF_WIDTH_PKT - 1;
    localparam int HEAD_POS  = DEF_WIDTH_PKT - 2;
    localparam int TAIL_POS  = DEF_WIDTH_PKT - 3;
    localparam int VC_POS    = TAIL_POS - DEF_VC_ADDRESS_WIDTH;
    localparam int DEST_POS  = VC_POS - DEF_ADDRESS_WIDTH;
    localparam int DATA_POS  = DEST_POS - DEF_WIDTH_DATA;

    // The arbiter helper supports up to 16 virtual channels.
    localparam int MAX_VC   = 16;
    localparam int MAX_VC_W = 4;
    typedef logic [MAX_VC_W-1:0] vc_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First requester found when searching upward from last+1, wrapping
    // modulo num_vc. The last grant itself has the lowest priority. With no
    // requester the previous grant is returned unchanged.
    function automatic int rr_next_grant(input logic [MAX_VC-1:0] req,
                                         input int                last,
                                         input int                num_vc);
        vc_idx_t idx;
        rr_next_grant = last;
        // Walk from the lowest priority upward so the closest requester wins.
        for (int i = MAX_VC; i >= 1; i--) begin
            if (i <= num_vc) begin
                idx = vc_idx_t'((last + i) % num_vc);
                if (req[idx]) begin
                    rr_next_grant = int'(idx);
                end
            end
        end
    endfunction

endpackage

// File: rtl/depacketizer_vc_fifo.sv
// ---------------------------------------------------------------------------
// depacketizer_vc_fifo
// First-word-fall-through FIFO with a separate occupancy counter. The head
// entry is always visible on rd_data_o. It is meaningful only while
// empty_o is 0.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (pointers and count only)
//   wr_en_i    push wr_data_i (ignored when full)
//   wr_data_i  entry to push
//   rd_en_i    pop the head entry (ignored when empty)
//   rd_data_o  head entry
//   full_o     count == DEPTH
//   empty_o    count == 0
// ---------------------------------------------------------------------------
module depacketizer_vc_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_ok   = wr_en_i && !full_o;
    assign rd_ok   = rd_en_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            // A simultaneous push and pop leaves the count unchanged.
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset. The count and pointers already define
    // which entries are live, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/depacketizer_vc_arb.sv
// ---------------------------------------------------------------------------
// depacketizer_vc_arb
// Splits incoming NoC flits into one FWFT buffer per virtual channel and
// round-robin arbitrates the buffered flits onto a single valid/ready
// stream.
// Optional feature: macro DEPKT_ARB_PKT_LOCK_EN keeps the grant on one VC
// from head transfer to tail transfer. This produces packet-atomic output.
// Without the macro the output interleaves VCs at flit granularity.
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   data_in       flit {valid, head, tail, vc, dest, payload}, MSB first
//   ready_out     per-VC credit, 1 while that VC buffer is not full
//   data_out      top WIDTH_DATA payload bits of the presented flit
//   vc_out        VC of the presented flit
//   eop_out       tail bit of the presented flit
//   valid_out     a flit is presented
//   ready_in      consumer accepts the presented flit
//   overflow_out  sticky: a valid flit arrived on a full VC and was dropped
// ---------------------------------------------------------------------------
module depacketizer_vc_arb
    import depacketizer_pkg::*;
#(
    parameter int WIDTH_PKT        = DEF_WIDTH_PKT,
    parameter int WIDTH_DATA       = DEF_WIDTH_DATA,
    parameter int VC_ADDRESS_WIDTH = DEF_VC_ADDRESS_WIDTH,
    parameter int ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH_PKT-1:0]          data_in,
    output logic [2**VC_ADDRESS_WIDTH-1:0] ready_out,
    output logic [WIDTH_DATA-1:0]         data_out,
    output logic [VC_ADDRESS_WIDTH-1:0]   vc_out,
    output logic                          eop_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          overflow_out
);

    localparam int NUM_VC  = 2**VC_ADDRESS_WIDTH;
    localparam int ENTRY_W = WIDTH_DATA + 2;   // {tail, head, data}
    localparam int SOP_BIT = WIDTH_DATA;
    localparam int EOP_BIT = WIDTH_DATA + 1;

    // The package positions describe the default layout. Rebase them onto
    // this instance's field widths.
    localparam int PKT_SHIFT = WIDTH_PKT - DEF_WIDTH_PKT;
    localparam int VC_SHIFT  = VC_ADDRESS_WIDTH - DEF_VC_ADDRESS_WIDTH;
    localparam int DST_SHIFT = ADDRESS_WIDTH - DEF_ADDRESS_WIDTH;
    localparam int VALID_P   = VALID_POS + PKT_SHIFT;
    localparam int HEAD_P    = HEAD_POS + PKT_SHIFT;
    localparam int TAIL_P    = TAIL_POS + PKT_SHIFT;
    localparam int VC_P      = VC_POS + PKT_SHIFT - VC_SHIFT;
    localparam int DEST_P    = DEST_POS + PKT_SHIFT - VC_SHIFT - DST_SHIFT;
    localparam int DATA_P    = DEST_P - WIDTH_DATA;

    typedef logic [VC_ADDRESS_WIDTH-1:0] vc_t;

    // ---------------- input side ----------------
    logic               flit_valid;
    vc_t                wr_vc;
    logic [ENTRY_W-1:0] wr_entry;
    logic [NUM_VC-1:0]  full;
    logic [NUM_VC-1:0]  empty;
    logic [ENTRY_W-1:0] rd_entry [NUM_VC];
    logic               unused_data_in;

    // An X on the valid bit counts as no flit. Only a definite 1 writes.
    assign flit_valid = (data_in[VALID_P] === 1'b1);
    assign wr_vc      = data_in[VC_P +: VC_ADDRESS_WIDTH];
    assign wr_entry   = {data_in[TAIL_P], data_in[HEAD_P],
                         data_in[DATA_P +: WIDTH_DATA]};
    // Destination and low payload bits are not forwarded.
    assign unused_data_in = ^data_in;

    // Credit comes from the registered count only. A pop in the same cycle
    // does not open space for a write into a full buffer.
    assign ready_out = rst_n ? ~full : '1;

    // ---------------- arbitration ----------------
    logic               transfer;
    logic [ENTRY_W-1:0] head_entry;
    logic [MAX_VC-1:0]  req_pad;
    vc_t                rr_grant;
    vc_t                grant;
    vc_t                last_grant_q;
    logic               hold_q;      // flit presented last cycle but not taken
    vc_t                hold_vc_q;
    logic               overflow_q;
`ifdef DEPKT_ARB_PKT_LOCK_EN
    arb_state_t         state_q;
    vc_t                lock_vc_q;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves a variable unassigned and infers a latch.
        req_pad             = '0;
        req_pad[NUM_VC-1:0] = ~empty;
        rr_grant = vc_t'(rr_next_grant(req_pad, int'(last_grant_q), NUM_VC));
        grant    = rr_grant;
        // A stalled flit keeps its VC so the outputs stay stable.
        if (hold_q) grant = hold_vc_q;
`ifdef DEPKT_ARB_PKT_LOCK_EN
        // Mid-packet the grant is pinned even when that VC runs dry.
        if (state_q == BUSY) grant = lock_vc_q;
`endif
    end

    assign head_entry = rd_entry[grant];
    assign valid_out  = rst_n && !empty[grant];
    assign transfer   = valid_out && ready_in;
    assign data_out   = valid_out ? head_entry[WIDTH_DATA-1:0] : '0;
    assign vc_out     = valid_out ? grant : '0;
    assign eop_out    = valid_out && head_entry[EOP_BIT];
    assign overflow_out = overflow_q;

`ifndef DEPKT_ARB_PKT_LOCK_EN
    logic unused_head;
    assign unused_head = head_entry[SOP_BIT];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= vc_t'(NUM_VC - 1);
            hold_q       <= 1'b0;
            hold_vc_q    <= '0;
            overflow_q   <= 1'b0;
`ifdef DEPKT_ARB_PKT_LOCK_EN
            state_q      <= IDLE;
            lock_vc_q    <= '0;
`endif
        end else begin
            if (flit_valid && full[wr_vc]) overflow_q <= 1'b1;

            if (transfer) begin
                last_grant_q <= grant;
                hold_q       <= 1'b0;
            end else if (valid_out) begin
                hold_q    <= 1'b1;
                hold_vc_q <= grant;
            end else begin
                hold_q    <= 1'b0;
            end

`ifdef DEPKT_ARB_PKT_LOCK_EN
            case (state_q)
                // Lock as soon as a head is granted. A head+tail flit that
                // transfers at once never leaves IDLE.
                IDLE: if (valid_out && head_entry[SOP_BIT] &&
                          !(transfer && head_entry[EOP_BIT])) begin
                    state_q   <= BUSY;
                    lock_vc_q <= grant;
                end
                BUSY: if (transfer && head_entry[EOP_BIT]) begin
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`endif
        end
    end

    // ---------------- per-VC buffers ----------------
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        depacketizer_vc_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (flit_valid && (wr_vc == vc_t'(v)) && !full[v]),
            .wr_data_i (wr_entry),
            .rd_en_i   (transfer && (grant == vc_t'(v))),
            .rd_data_o (rd_entry[v]),
            .full_o    (full[v]),
            .empty_o   (empty[v])
        );
    end

endmodule

// File: tb/tb_depacketizer_vc_arb.sv
// ---------------------------------------------------------------------------
// tb_depacketizer_vc_arb
// Directed bench for depacketizer_vc_arb in its default geometry.
// A cycle table covers reset, single flits, overflow and same-cycle
// push/pop. Hand-written sequences cover arbitration order, stall/hold
// behaviour and reset in the middle of a packet.
// ---------------------------------------------------------------------------
module tb_depacketizer_vc_arb;
    import depacketizer_pkg::*;

    localparam int WP  = 36;
    localparam int WD  = 12;
    localparam int VCW = 1;
    localparam int AW  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [WP-1:0]  data_in;
    logic [1:0]     ready_out;
    logic [WD-1:0]  data_out;
    logic [VCW-1:0] vc_out;
    logic           eop_out;
    logic           valid_out;
    logic           ready_in;
    logic           overflow_out;

    always #5 clk = ~clk;

    depacketizer_vc_arb #(
        .WIDTH_PKT        (WP),
        .WIDTH_DATA       (WD),
        .VC_ADDRESS_WIDTH (VCW),
        .ADDRESS_WIDTH    (AW),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .vc_out       (vc_out),
        .eop_out      (eop_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .overflow_out (overflow_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WP-1:0] flit(input logic v, input logic h,
                                           input logic t,
                                           input logic [VCW-1:0] vc,
                                           input logic [WD-1:0] d);
        logic [WP-1:0] f;
        f                   = '0;
        f[VALID_POS]        = v;
        f[HEAD_POS]         = h;
        f[TAIL_POS]         = t;
        f[VC_POS +: VCW]    = vc;
        f[DEST_POS +: AW]   = 4'h9;
        f[DATA_POS +: WD]   = d;
        f[DATA_POS-1:0]     = 16'h5A5A;   // low payload bits must not leak
        return f;
    endfunction

    typedef struct {
        logic           rst;
        logic [WP-1:0]  din;
        logic           rdy;
        logic           e_valid;
        logic [WD-1:0]  e_data;
        logic [VCW-1:0] e_vc;
        logic           e_eop;
        logic [1:0]     e_rdy_out;
        logic           e_ovf;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [WP-1:0] din,
                                input logic rdy, input logic ev,
                                input logic [WD-1:0] ed,
                                input logic [VCW-1:0] evc, input logic eeop,
                                input logic [1:0] er, input logic eo);
        vec_t r;
        r.rst = rst; r.din = din; r.rdy = rdy; r.e_valid = ev; r.e_data = ed;
        r.e_vc = evc; r.e_eop = eeop; r.e_rdy_out = er; r.e_ovf = eo;
        return r;
    endfunction

    localparam int NV = 22;
    vec_t tbl [NV];

    // {eop, vc, data} of every accepted output flit.
    logic [WD+VCW:0] got_q [$];

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    task automatic send(input logic [WP-1:0] f);
        @(negedge clk);
        data_in = f;
    endtask

    // Accept with ready_in=1 until n flits are collected or time runs out.
    task automatic drain(input string name, input int n, input int max_cyc);
        got_q.delete();
        for (int c = 0; c < max_cyc && got_q.size() < n; c++) begin
            @(negedge clk);
            data_in  = '0;
            ready_in = 1'b1;
            #1;
            if (valid_out) got_q.push_back({eop_out, vc_out, data_out});
        end
        check({name, " count"}, 32'(got_q.size()), 32'(n));
    endtask

    logic [WP-1:0]   fx;
    logic [WD+VCW:0] exp_seq [6];
    logic            prev_stall;
    logic [WD+VCW:0] prev_out;

    initial begin
        rst_n    = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;
        repeat (2) @(posedge clk);

        // ---------------- table-driven cycles ----------------
        fx            = flit(1'b1, 1'b1, 1'b1, 1'b0, 12'hDEF);
        fx[VALID_POS] = 1'bx;
        tbl[0]  = mk(0, '0, 1, 0, 12'h000, 0, 0, 2'b11, 0);
        tbl[1]  = mk(1, flit(1, 1, 1, 0, 12'hABC), 1, 0, 12'h000, 0, 0, 2'b11, 0);
        tbl[2]  = mk(1, '0, 1, 1, 12'hABC, 0, 1, 2'b11, 0);
        tbl[3]  = mk(1, '0, 1, 0, 12'h000, 0, 0, 2'b11, 0);
        tbl[4]  = mk(1, fx, 1, 0, 12'h000, 0, 0, 2'b11, 0);
        tbl[5]  = mk(1, '0, 1, 0, 12'h000, 0, 0, 2'b11, 0);
        tbl[6]  = mk(1, flit(0, 1, 1, 0, 12'hEEE), 1, 0, 12'h000, 0, 0, 2'b11, 0);
        tbl[7]  = mk(1, '0, 1, 0, 12'h000, 0, 0, 2'b11, 0);
        tbl[8]  = mk(1, flit(1, 1, 0, 1, 12'h111), 0, 0, 12'h000, 0, 0, 2'b11, 0);
        tbl[9]  = mk(1, flit(1, 0, 0, 1, 12'h222), 0, 1, 12'h111, 1, 0, 2'b11, 0);
        tbl[10] = mk(1, flit(1, 0, 0, 1, 12'h333), 0, 1, 12'h111, 1, 0, 2'b11, 0);
        tbl[11] = mk(1, flit(1, 0, 1, 1, 12'h444), 0, 1, 12'h111, 1, 0, 2'b11, 0);
        tbl[12] = mk(1, flit(1, 1, 1, 1, 12'h555), 0, 1, 12'h111, 1, 0, 2'b01, 0);
        tbl[13] = mk(1, flit(1, 1, 1, 1, 12'h666), 1, 1, 12'h111, 1, 0, 2'b01, 1);
        tbl[14] = mk(1, '0, 1, 1, 12'h222, 1, 0, 2'b11, 1);
        tbl[15] = mk(1, '0, 1, 1, 12'h333, 1, 0, 2'b11, 1);
        tbl[16] = mk(1, '0, 1, 1, 12'h444, 1, 1, 2'b11, 1);
        tbl[17] = mk(1, '0, 1, 0, 12'h000, 0, 0, 2'b11, 1);
        tbl[18] = mk(1, flit(1, 1, 1, 0, 12'h777), 1, 0, 12'h000, 0, 0, 2'b11, 1);
        tbl[19] = mk(1, flit(1, 1, 1, 0, 12'h888), 1, 1, 12'h777, 0, 1, 2'b11, 1);
        tbl[20] = mk(1, '0, 1, 1, 12'h888, 0, 1, 2'b11, 1);
        tbl[21] = mk(1, '0, 1, 0, 12'h000, 0, 0, 2'b11, 1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n    = tbl[i].rst;
            data_in  = tbl[i].din;
            ready_in = tbl[i].rdy;
            #1;
            check($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(tbl[i].e_valid));
            check($sformatf("row%0d data_out", i), 32'(data_out), 32'(tbl[i].e_data));
            check($sformatf("row%0d vc_out", i), 32'(vc_out), 32'(tbl[i].e_vc));
            check($sformatf("row%0d eop_out", i), 32'(eop_out), 32'(tbl[i].e_eop));
            check($sformatf("row%0d ready_out", i), 32'(ready_out), 32'(tbl[i].e_rdy_out));
            check($sformatf("row%0d overflow_out", i), 32'(overflow_out), 32'(tbl[i].e_ovf));
        end

        // ---------------- interleaved 3-flit packets ----------------
        do_reset();
        send(flit(1, 1, 0, 0, 12'hA00));
        send(flit(1, 1, 0, 1, 12'hB00));
        send(flit(1, 0, 0, 0, 12'hA01));
        send(flit(1, 0, 0, 1, 12'hB01));
        send(flit(1, 0, 1, 0, 12'hA02));
        send(flit(1, 0, 1, 1, 12'hB02));
`ifdef DEPKT_ARB_PKT_LOCK_EN
        exp_seq = '{{1'b0, 1'b0, 12'hA00}, {1'b0, 1'b0, 12'hA01},
                    {1'b1, 1'b0, 12'hA02}, {1'b0, 1'b1, 12'hB00},
                    {1'b0, 1'b1, 12'hB01}, {1'b1, 1'b1, 12'hB02}};
`else
        exp_seq = '{{1'b0, 1'b0, 12'hA00}, {1'b0, 1'b1, 12'hB00},
                    {1'b0, 1'b0, 12'hA01}, {1'b0, 1'b1, 12'hB01},
                    {1'b1, 1'b0, 12'hA02}, {1'b1, 1'b1, 12'hB02}};
`endif
        drain("interleave", 6, 40);
        for (int k = 0; k < 6; k++)
            check($sformatf("interleave flit%0d", k), 32'(got_q[k]), 32'(exp_seq[k]));

        // ---------------- ready_in toggling ----------------
        do_reset();
        send(flit(1, 1, 0, 0, 12'h101));
        send(flit(1, 0, 0, 0, 12'h102));
        send(flit(1, 0, 0, 0, 12'h103));
        send(flit(1, 0, 1, 0, 12'h104));
        got_q.delete();
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
            @(negedge clk);
            data_in  = '0;
            ready_in = (c % 2 == 1);
            #1;
            if (prev_stall)
                check($sformatf("stall hold cyc%0d", c),
                      32'({valid_out, eop_out, vc_out, data_out}),
                      32'({1'b1, prev_out}));
            if (valid_out && ready_in) got_q.push_back({eop_out, vc_out, data_out});
            prev_stall = valid_out && !ready_in;
            prev_out   = {eop_out, vc_out, data_out};
        end
        check("toggle count", 32'(got_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("toggle flit%0d", k), 32'(got_q[k]),
                  32'({(k == 3), 1'b0, 12'h101 + 12'(k)}));
        @(negedge clk);
        ready_in = 1'b1;
        #1;
        check("toggle no duplicate", 32'(valid_out), 32'd0);

        // ---------------- reset mid-packet ----------------
        do_reset();
        send(flit(1, 1, 0, 0, 12'hC00));
        @(negedge clk);
        rst_n   = 1'b0;
        data_in = flit(1, 0, 0, 0, 12'hC01);
        #1;
        check("during reset valid_out", 32'(valid_out), 32'd0);
        check("during reset ready_out", 32'(ready_out), 32'h3);
        @(negedge clk);
        rst_n   = 1'b1;
        data_in = '0;
        #1;
        check("after reset valid_out", 32'(valid_out), 32'd0);
        check("after reset ready_out", 32'(ready_out), 32'h3);
        check("after reset data_out", 32'({eop_out, vc_out, data_out}), 32'd0);
        check("after reset overflow_out", 32'(overflow_out), 32'd0);
        send(flit(1, 1, 1, 1, 12'hD00));
        drain("post-reset", 1, 10);
        check("post-reset flit", 32'(got_q[0]), 32'({1'b1, 1'b1, 12'hD00}));
        @(negedge clk);
        #1;
        check("post-reset no stale flit", 32'(valid_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
